acl_iface_pll_reset_seq: RTL and testbench

Reset sequencer and lock supervisor for the ACL interface PLL. It runs on the PLL reference clock, pulses the PLL reset, waits for lock, and debounces lock before releasing the downstream kernel reset. It retries on lock timeout and restarts the sequence on lock loss or on a software request. It sits between the board reset and the `system_acl_iface` PLL instance; its outputs drive the PLL `rst` input and the kernel-domain reset synchronizer.

---
 rtl/acl_iface_pll_pkg.sv | 23 ++
 rtl/acl_sync2.sv | 31 +++
 rtl/acl_iface_pll_reset_seq.sv | 145 ++++++++++++++
 tb/tb_acl_iface_pll_reset_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/acl_iface_pll_pkg.sv
// acl_iface_pll_pkg: shared types for the ACL interface PLL reset sequencer.
// Rev 1.0
`default_nettype none

package acl_iface_pll_pkg;

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABILIZE = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } pll_seq_state_t;

   localparam logic [7:0] C_LOSS_MAX = 8'hFF;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == C_LOSS_MAX) ? v : v + 8'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/acl_sync2.sv
// acl_sync2: parameterizable two-flop synchronizer, async active-low reset.
// Rev 1.0
`default_nettype none

module acl_sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/acl_iface_pll_reset_seq.sv
// acl_iface_pll_reset_seq: PLL reset pulse, lock wait/debounce, retry and lock-loss supervision.
// Rev 1.0
`default_nettype none

module acl_iface_pll_reset_seq
   import acl_iface_pll_pkg::*;
#(
   parameter int RST_ASSERT_CYCLES   = 64,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 1000000,
   parameter int MAX_RETRIES         = 3,
   parameter int CNT_W               = 20,
   localparam int RETRY_W            = $clog2(MAX_RETRIES + 1)
) (
   input  logic               refclk_i,
   input  logic               reset_n_i,
   input  logic               sw_reset_req_i,
   input  logic               pll_locked_i,
   output logic               pll_rst_o,
   output logic               kernel_reset_n_o,
   output logic               status_ready_o,
   output logic               status_fail_o,
   output logic [RETRY_W-1:0] retry_count_o,
   output logic [7:0]         lock_loss_count_o
);

   localparam logic [CNT_W-1:0]   C_RST_LAST     = CNT_W'(RST_ASSERT_CYCLES - 1);
   localparam logic [CNT_W-1:0]   C_STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [RETRY_W-1:0] C_RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

   logic lock_s;

   pll_seq_state_t     state_q,  state_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [RETRY_W-1:0] retry_q,  retry_d;
   logic [7:0]         loss_q,   loss_d;
   logic               pll_rst_q;
   logic               kernel_reset_n_q;
   logic               ready_q;
   logic               fail_q;

   acl_sync2 #(
      .WIDTH (1)
   ) u_lock_sync (
      .clk_i   (refclk_i),
      .rst_n_i (reset_n_i),
      .d_i     (pll_locked_i),
      .q_o     (lock_s)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      retry_d = retry_q;
      loss_d  = loss_q;

      // A lock drop in RUN is counted even when a software request wins the cycle.
      if (state_q == RUN && !lock_s) begin
         loss_d = sat_inc8(loss_q);
      end

      if (sw_reset_req_i) begin
         state_d = RESET_PLL;
         cnt_d   = '0;
         retry_d = '0;
      end else begin
         case (state_q)
            RESET_PLL: begin
               if (cnt_q == C_RST_LAST) begin
                  state_d = WAIT_LOCK;
               end
            end
            WAIT_LOCK: begin
               if (lock_s) begin
                  state_d = STABILIZE;
               end else if (cnt_q == C_TIMEOUT_LAST) begin
                  if (retry_q < C_RETRY_LIMIT) begin
                     retry_d = retry_q + RETRY_W'(1);
                     state_d = RESET_PLL;
                  end else begin
                     state_d = FAIL;
                  end
               end
            end
            STABILIZE: begin
               if (!lock_s) begin
                  state_d = WAIT_LOCK;
               end else if (cnt_q == C_STABLE_LAST) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (!lock_s) begin
                  retry_d = '0;
                  state_d = RESET_PLL;
               end
            end
            FAIL: begin
               state_d = FAIL;
            end
            default: begin
               state_d = RESET_PLL;
            end
         endcase
      end

      if (state_d != state_q) begin
         cnt_d = '0;
      end
   end

   // Outputs are decoded from the next state so they switch on the same edge as the state.
   always_ff @(posedge refclk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q          <= RESET_PLL;
         cnt_q            <= '0;
         retry_q          <= '0;
         loss_q           <= '0;
         pll_rst_q        <= 1'b1;
         kernel_reset_n_q <= 1'b0;
         ready_q          <= 1'b0;
         fail_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         retry_q          <= retry_d;
         loss_q           <= loss_d;
         pll_rst_q        <= (state_d == RESET_PLL) || (state_d == FAIL);
         kernel_reset_n_q <= (state_d == RUN);
         ready_q          <= (state_d == RUN);
         fail_q           <= (state_d == FAIL);
      end
   end

   assign pll_rst_o         = pll_rst_q;
   assign kernel_reset_n_o  = kernel_reset_n_q;
   assign status_ready_o    = ready_q;
   assign status_fail_o     = fail_q;
   assign retry_count_o     = retry_q;
   assign lock_loss_count_o = loss_q;

endmodule

`default_nettype wire

// File: tb/tb_acl_iface_pll_reset_seq.sv
// tb_acl_iface_pll_reset_seq: directed stimulus with a countdown/phase reference model.
// Rev 1.0
`default_nettype none

module tb_acl_iface_pll_reset_seq;

   localparam int R  = 4;
   localparam int S  = 8;
   localparam int T  = 32;
   localparam int MR = 2;

   localparam int P_RESET = 0;
   localparam int P_WAIT  = 1;
   localparam int P_STAB  = 2;
   localparam int P_RUN   = 3;
   localparam int P_FAIL  = 4;

   logic       refclk       = 1'b0;
   logic       reset_n      = 1'b0;
   logic       sw_reset_req = 1'b0;
   logic       pll_locked   = 1'b0;
   logic       pll_rst;
   logic       kernel_reset_n;
   logic       status_ready;
   logic       status_fail;
   logic [1:0] retry_count;
   logic [7:0] lock_loss_count;

   int checks   = 0;
   int failures = 0;

   acl_iface_pll_reset_seq #(
      .RST_ASSERT_CYCLES   (R),
      .LOCK_STABLE_CYCLES  (S),
      .LOCK_TIMEOUT_CYCLES (T),
      .MAX_RETRIES         (MR),
      .CNT_W               (20)
   ) dut (
      .refclk_i          (refclk),
      .reset_n_i         (reset_n),
      .sw_reset_req_i    (sw_reset_req),
      .pll_locked_i      (pll_locked),
      .pll_rst_o         (pll_rst),
      .kernel_reset_n_o  (kernel_reset_n),
      .status_ready_o    (status_ready),
      .status_fail_o     (status_fail),
      .retry_count_o     (retry_count),
      .lock_loss_count_o (lock_loss_count)
   );

   always #5 refclk = ~refclk;

   // Reference: phase plus cycles remaining in it, and a 2-deep history of pll_locked.
   typedef struct packed {
      int         phase;
      int         left;
      int         retries;
      int         losses;
      logic [1:0] hist;
   } model_t;

   model_t m;

   function automatic model_t m_reset();
      model_t r;
      r.phase   = P_RESET;
      r.left    = R;
      r.retries = 0;
      r.losses  = 0;
      r.hist    = 2'b00;
      return r;
   endfunction

   function automatic model_t m_step(input model_t s, input logic lk, input logic req);
      model_t n;
      logic   ls;
      n      = s;
      ls     = s.hist[1];
      n.hist = {s.hist[0], lk};
      if (s.phase == P_RUN && !ls && s.losses < 255) n.losses = s.losses + 1;
      if (req) begin
         n.phase   = P_RESET;
         n.left    = R;
         n.retries = 0;
      end else begin
         case (s.phase)
            P_RESET: begin
               n.left = s.left - 1;
               if (n.left == 0) begin n.phase = P_WAIT; n.left = T; end
            end
            P_WAIT: begin
               if (ls) begin
                  n.phase = P_STAB; n.left = S;
               end else begin
                  n.left = s.left - 1;
                  if (n.left == 0) begin
                     if (s.retries < MR) begin
                        n.retries = s.retries + 1; n.phase = P_RESET; n.left = R;
                     end else begin
                        n.phase = P_FAIL;
                     end
                  end
               end
            end
            P_STAB: begin
               if (!ls) begin
                  n.phase = P_WAIT; n.left = T;
               end else begin
                  n.left = s.left - 1;
                  if (n.left == 0) n.phase = P_RUN;
               end
            end
            P_RUN: begin
               if (!ls) begin n.phase = P_RESET; n.left = R; n.retries = 0; end
            end
            default: begin end
         endcase
      end
      return n;
   endfunction

   always @(posedge refclk or negedge reset_n) begin
      if (!reset_n) m <= m_reset();
      else          m <= m_step(m, pll_locked, sw_reset_req);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge refclk) begin
      chk("m_pll_rst",    32'(pll_rst),         32'(m.phase == P_RESET || m.phase == P_FAIL));
      chk("m_kernel_rst", 32'(kernel_reset_n),  32'(m.phase == P_RUN));
      chk("m_ready",      32'(status_ready),    32'(m.phase == P_RUN));
      chk("m_fail",       32'(status_fail),     32'(m.phase == P_FAIL));
      chk("m_retry",      32'(retry_count),     32'(m.retries));
      chk("m_loss",       32'(lock_loss_count), 32'(m.losses));
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge refclk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pll_rst"}, 32'(pll_rst),         32'd1);
      chk({tag, "_krst"},    32'(kernel_reset_n),  32'd0);
      chk({tag, "_ready"},   32'(status_ready),    32'd0);
      chk({tag, "_fail"},    32'(status_fail),     32'd0);
      chk({tag, "_retry"},   32'(retry_count),     32'd0);
      chk({tag, "_loss"},    32'(lock_loss_count), 32'd0);
   endtask

   initial begin
      // Reset values
      cyc(3);
      chk_reset_vals("rst");
      reset_n = 1'b1;

      // Nominal lock: pll_locked sampled from edge 10
      cyc(3);  chk("nom_rst_hi_e2", 32'(pll_rst), 32'd1);
      cyc(1);  chk("nom_rst_lo_e3", 32'(pll_rst), 32'd0);
      cyc(6);  pll_locked = 1'b1;
      cyc(10); chk("nom_krst_e19", 32'(kernel_reset_n), 32'd0);
      cyc(1);  chk("nom_krst_e20", 32'(kernel_reset_n), 32'd1);
      chk("nom_ready", 32'(status_ready), 32'd1);
      chk("nom_retry", 32'(retry_count), 32'd0);

      // Lock loss in RUN
      cyc(3);
      pll_locked = 1'b0;
      cyc(2);  chk("loss_krst_2", 32'(kernel_reset_n), 32'd1);
      cyc(1);  chk("loss_krst_3", 32'(kernel_reset_n), 32'd0);
      chk("loss_cnt1", 32'(lock_loss_count), 32'd1);
      pll_locked = 1'b1;
      cyc(20); chk("loss_relock", 32'(status_ready), 32'd1);

      // Glitchy lock in STABILIZE after a software restart
      sw_reset_req = 1'b1; cyc(1); sw_reset_req = 1'b0;
      cyc(3);  chk("gl_rst_hi", 32'(pll_rst), 32'd1);
      cyc(1);  chk("gl_rst_lo", 32'(pll_rst), 32'd0);
      cyc(5);  pll_locked = 1'b0;
      cyc(1);  pll_locked = 1'b1;
      cyc(10); chk("gl_not_run", 32'(status_ready), 32'd0);
      chk("gl_retry", 32'(retry_count), 32'd0);
      cyc(1);  chk("gl_run", 32'(status_ready), 32'd1);

      // Software requests in STABILIZE and in RESET_PLL
      sw_reset_req = 1'b1; cyc(1); sw_reset_req = 1'b0;
      cyc(5);
      sw_reset_req = 1'b1; cyc(1); sw_reset_req = 1'b0;
      cyc(1);
      sw_reset_req = 1'b1; cyc(1); sw_reset_req = 1'b0;
      cyc(3);  chk("sw_rst_hi", 32'(pll_rst), 32'd1);
      cyc(1);  chk("sw_rst_lo", 32'(pll_rst), 32'd0);
      cyc(15); chk("sw_run", 32'(status_ready), 32'd1);

      // Software request coinciding with a lock drop in RUN
      pll_locked = 1'b0;
      cyc(2);  sw_reset_req = 1'b1;
      cyc(1);  sw_reset_req = 1'b0;
      chk("both_loss2", 32'(lock_loss_count), 32'd2);
      chk("both_rst",   32'(pll_rst), 32'd1);
      pll_locked = 1'b1;
      cyc(20); chk("both_run", 32'(status_ready), 32'd1);

      // Timeouts to FAIL
      pll_locked = 1'b0;
      cyc(38); chk("to_retry0", 32'(retry_count), 32'd0);
      cyc(1);  chk("to_retry1", 32'(retry_count), 32'd1);
      chk("to_rst1", 32'(pll_rst), 32'd1);
      cyc(36); chk("to_retry2", 32'(retry_count), 32'd2);
      cyc(35); chk("to_nofail", 32'(status_fail), 32'd0);
      cyc(1);  chk("to_fail", 32'(status_fail), 32'd1);
      cyc(40); chk("to_fail_hold", 32'(status_fail), 32'd1);
      chk("to_fail_rst", 32'(pll_rst), 32'd1);
      sw_reset_req = 1'b1; cyc(1); sw_reset_req = 1'b0;
      chk("to_sw_fail", 32'(status_fail), 32'd0);
      chk("to_sw_retry", 32'(retry_count), 32'd0);
      chk("to_sw_rst", 32'(pll_rst), 32'd1);
      pll_locked = 1'b1;
      cyc(25); chk("to_relock", 32'(status_ready), 32'd1);
      chk("to_loss3", 32'(lock_loss_count), 32'd3);

      // Saturation of the lock-loss counter
      for (int i = 0; i < 256; i++) begin
         pll_locked = 1'b0; cyc(3);
         pll_locked = 1'b1; cyc(14);
         if (i == 99) chk("sat_mid", 32'(lock_loss_count), 32'd103);
      end
      chk("sat_255", 32'(lock_loss_count), 32'd255);
      chk("sat_run", 32'(status_ready), 32'd1);

      // Asynchronous reset mid-RUN
      @(posedge refclk);
      #2 reset_n = 1'b0;
      #1 chk_reset_vals("arst");
      cyc(2);
      reset_n = 1'b1;
      cyc(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
